pose_match_scorer: RTL



---
 rtl/pose_match_scorer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pose_match_scorer.sv
// Windowed intersection/union pixel counter with a sequential divider that scores overlap 0..100.
// Optional feature macro: SCORE_SMOOTH_EN (exponential smoothing of the reported score).
module pose_match_scorer #(
   parameter int         X0     = 200,
   parameter int         Y0     = 200,
   parameter int         WIDTH  = 320,
   parameter int         HEIGHT = 240,
   parameter logic [3:0] THRESH = 4'd8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [11:0] truth_pixel_in,
   input  logic        user_mask_in,
   output logic [6:0]  score_out,
   output logic        score_valid_out,
   output logic        busy_out,
   output logic        overrun_out
);

   localparam logic [10:0] X_LO = 11'(X0);
   localparam logic [10:0] X_HI = 11'(X0 + WIDTH - 1);
   localparam logic [9:0]  Y_LO = 10'(Y0);
   localparam logic [9:0]  Y_HI = 10'(Y0 + HEIGHT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LATCH  = 2'd1,
      S_DIVIDE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   function automatic logic [16:0] sat_inc(input logic [16:0] cnt, input logic inc);
      if (cnt == 17'h1FFFF) begin
         sat_inc = cnt;
      end else begin
         sat_inc = cnt + {16'd0, inc};
      end
   endfunction

   state_t      state_q, state_d;
   logic [16:0] inter_q, inter_d, union_q, union_d;
   logic [16:0] inter_l_q, inter_l_d, union_l_q, union_l_d;
   logic [23:0] dividend_q, dividend_d;
   logic [16:0] divisor_q, divisor_d;
   logic [16:0] rem_q, rem_d;
   logic [6:0]  quot_q, quot_d;
   logic [4:0]  bit_q, bit_d;
   logic [6:0]  score_q, score_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
`ifdef SCORE_SMOOTH_EN
   logic [6:0]  avg_q, avg_d;
   logic        avg_vld_q, avg_vld_d;
   logic [8:0]  blend;
`endif

   logic        in_win, start_px, end_px, t_fg, u_fg;
   logic [17:0] rem_sh;
   logic [6:0]  raw_score;
   logic        unused_pix;

   assign unused_pix = ^truth_pixel_in[7:0];
   assign in_win   = (hcount_in >= X_LO) && (hcount_in <= X_HI) &&
                     (vcount_in >= Y_LO) && (vcount_in <= Y_HI);
   assign start_px = (hcount_in == X_LO) && (vcount_in == Y_LO);
   assign end_px   = (hcount_in == X_HI) && (vcount_in == Y_HI);
   assign t_fg     = (truth_pixel_in[11:8] >= THRESH);
   assign u_fg     = user_mask_in;

   // Next-state logic: free-running window counters plus the latch/divide/done sequencer.
   always_comb begin
      state_d    = state_q;
      inter_d    = inter_q;
      union_d    = union_q;
      inter_l_d  = inter_l_q;
      union_l_d  = union_l_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      bit_d      = bit_q;
      score_d    = score_q;
      valid_d    = 1'b0;
      overrun_d  = overrun_q;
      rem_sh     = 18'd0;
      raw_score  = 7'd0;
`ifdef SCORE_SMOOTH_EN
      avg_d      = avg_q;
      avg_vld_d  = avg_vld_q;
      blend      = 9'd0;
`endif

      // The start pixel reloads rather than clears, so each window counts itself exactly once.
      if (start_px) begin
         inter_d = {16'd0, t_fg & u_fg};
         union_d = {16'd0, t_fg | u_fg};
      end else if (in_win) begin
         inter_d = sat_inc(inter_q, t_fg & u_fg);
         union_d = sat_inc(union_q, t_fg | u_fg);
      end else begin
         inter_d = inter_q;
         union_d = union_q;
      end

      if (end_px && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      case (state_q)
         S_IDLE: begin
            if (end_px) begin
               inter_l_d = inter_d;
               union_l_d = union_d;
               state_d   = S_LATCH;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_LATCH: begin
            dividend_d = 24'(inter_l_q) * 24'd100;
            divisor_d  = union_l_q;
            rem_d      = 17'd0;
            quot_d     = 7'd0;
            bit_d      = 5'd23;
            state_d    = S_DIVIDE;
         end
         S_DIVIDE: begin
            rem_sh = {rem_q, dividend_q[bit_q]};
            if (rem_sh >= {1'b0, divisor_q}) begin
               rem_d = 17'(rem_sh - {1'b0, divisor_q});
               if (bit_q < 5'd7) begin
                  quot_d[bit_q[2:0]] = 1'b1;
               end else begin
                  quot_d = quot_q;
               end
            end else begin
               rem_d = rem_sh[16:0];
            end
            if (bit_q == 5'd0) begin
               state_d = S_DONE;
            end else begin
               bit_d   = bit_q - 5'd1;
            end
         end
         S_DONE: begin
            // An empty union divides by zero; report zero overlap instead.
            if (union_l_q == 17'd0) begin
               raw_score = 7'd0;
            end else begin
               raw_score = quot_q;
            end
`ifdef SCORE_SMOOTH_EN
            if (avg_vld_q) begin
               blend = (9'd3 * {2'd0, avg_q} + {2'd0, raw_score}) >> 2;
               avg_d = blend[6:0];
            end else begin
               avg_d = raw_score;
            end
            avg_vld_d = 1'b1;
            score_d   = avg_d;
`else
            score_d   = raw_score;
`endif
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_d = (state_d != S_IDLE);

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         inter_q    <= 17'd0;
         union_q    <= 17'd0;
         inter_l_q  <= 17'd0;
         union_l_q  <= 17'd0;
         dividend_q <= 24'd0;
         divisor_q  <= 17'd0;
         rem_q      <= 17'd0;
         quot_q     <= 7'd0;
         bit_q      <= 5'd0;
         score_q    <= 7'd0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef SCORE_SMOOTH_EN
         avg_q      <= 7'd0;
         avg_vld_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         inter_q    <= inter_d;
         union_q    <= union_d;
         inter_l_q  <= inter_l_d;
         union_l_q  <= union_l_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         bit_q      <= bit_d;
         score_q    <= score_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
`ifdef SCORE_SMOOTH_EN
         avg_q      <= avg_d;
         avg_vld_q  <= avg_vld_d;
`endif
      end
   end

   assign score_out       = score_q;
   assign score_valid_out = valid_q;
   assign busy_out        = busy_q;
   assign overrun_out     = overrun_q;

endmodule
